vga_timing: RTL and testbench



---
 rtl/vga_timing.sv | 95 +++++++++
 tb/tb_vga_timing.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - free-running VGA timing generator (hcount/vcount, sync, blanking, frame_start)
// Every flag is decoded from the next-state counters so the whole bus leaves the flops aligned.
module vga_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [11:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [11:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_mode
      $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 4096");
    end
  endgenerate

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] HB_START = 12'(H_ACTIVE);
  localparam logic [11:0] VB_START = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [11:0] hcount_q, hcount_d;
  logic [11:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vsync_q, vsync_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q, frame_start_d;
  logic        h_wrap, v_wrap;

  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    hcount_d = h_wrap ? 12'd0 : hcount_q + 12'd1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? 12'd0 : vcount_q + 12'd1;
    end
    // Decode from the values about to be registered, keeping flags in step with the counters.
    hblnk_d       = (hcount_d >= HB_START);
    vblnk_d       = (vcount_d >= VB_START);
    hsync_d       = (hcount_d >= HS_START) && (hcount_d <= HS_END);
    vsync_d       = (vcount_d >= VS_START) && (vcount_d <= VS_END);
    frame_start_d = h_wrap && v_wrap;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_q      <= 12'd0;
      vcount_q      <= 12'd0;
      hsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vsync_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      hblnk_q       <= hblnk_d;
      vsync_q       <= vsync_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign hblnk       = hblnk_q;
  assign vsync       = vsync_q;
  assign vblnk       = vblnk_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed bench for vga_timing in default, 640x480 and a tiny mode
// The tiny mode (line 15, frame 12 lines) makes whole-frame behaviour reachable in a short run.
`timescale 1ns/1ps
module tb_vga_timing;

  logic pclk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [11:0] d_h, d_v, g_h, g_v, s_h, s_v;
  logic d_hs, d_hb, d_vs, d_vb, d_fs;
  logic g_hs, g_hb, g_vs, g_vb, g_fs;
  logic s_hs, s_hb, s_vs, s_vb, s_fs;

  always #5 if (clk_en) pclk = ~pclk;

  vga_timing u_def (
    .pclk(pclk), .rst(rst), .hcount(d_h), .hsync(d_hs), .hblnk(d_hb),
    .vcount(d_v), .vsync(d_vs), .vblnk(d_vb), .frame_start(d_fs)
  );

  vga_timing #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33)
  ) u_vga (
    .pclk(pclk), .rst(rst), .hcount(g_h), .hsync(g_hs), .hblnk(g_hb),
    .vcount(g_v), .vsync(g_vs), .vblnk(g_vb), .frame_start(g_fs)
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .pclk(pclk), .rst(rst), .hcount(s_h), .hsync(s_hs), .hblnk(s_hb),
    .vcount(s_v), .vsync(s_vs), .vblnk(s_vb), .frame_start(s_fs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  function automatic logic [28:0] pk(input logic [11:0] h, input logic [11:0] v,
                                     input logic hs, input logic hb, input logic vs,
                                     input logic vb, input logic fs);
    return {h, v, hs, hb, vs, vb, fs};
  endfunction

  // Tiny-mode reference derived from the cycle count since reset release.
  function automatic logic [28:0] exp_small(input int c);
    int h, v;
    h = c % 15;
    v = (c / 15) % 12;
    return pk(12'(h), 12'(v), (h >= 10 && h <= 12), (h >= 8), (v >= 7 && v <= 8),
              (v >= 6), (c > 0 && c % 180 == 0));
  endfunction

  function automatic logic [28:0] obs_small();
    return pk(s_h, s_v, s_hs, s_hb, s_vs, s_vb, s_fs);
  endfunction

  initial begin
    int cnt, hs_rises, vs_hi;
    logic prev_hs;

    // Bring up, run a few cycles, then stop the clock and reset asynchronously.
    clk_en = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    rst = 1'b0;
    cyc = 0;
    repeat (5) step();
    check("pre_reset_hcount", 32'(d_h), 32'd5);
    clk_en = 1'b0;
    #20;
    rst = 1'b1;
    #2;
    check("async_rst_hcount", 32'(d_h), 32'd0);
    check("async_rst_vcount", 32'(d_v), 32'd0);
    check("async_rst_flags", 32'({d_hs, d_hb, d_vs, d_vb, d_fs}), 32'd0);
    #10;
    rst = 1'b0;
    #10;
    check("released_no_clk", 32'({d_h, d_v, d_hs, d_hb, d_vs, d_vb, d_fs}), 32'd0);
    cyc = 0;
    clk_en = 1'b1;
    step();
    check("first_edge_hcount", 32'(d_h), 32'd1);
    check("first_edge_vcount", 32'(d_v), 32'd0);
    check("first_edge_fs", 32'(d_fs), 32'd0);

    // Horizontal edges: 640x480 and default mode side by side.
    run_to(639);
    check("vga_hblnk_639", 32'(g_hb), 32'd0);
    step();
    check("vga_hblnk_640", 32'(g_hb), 32'd1);
    run_to(655);
    check("vga_hsync_655", 32'(g_hs), 32'd0);
    step();
    check("vga_hsync_656", 32'(g_hs), 32'd1);
    run_to(751);
    check("vga_hsync_751", 32'(g_hs), 32'd1);
    step();
    check("vga_hsync_752", 32'(g_hs), 32'd0);
    run_to(799);
    check("def_hblnk_799", 32'(d_hb), 32'd0);
    check("vga_hcount_799", 32'(g_h), 32'd799);
    step();
    check("def_hblnk_800", 32'({d_h, 3'b000, d_hb}), {12'd800, 4'b0001});
    check("vga_wrap_800", 32'({g_h, g_v, g_hb}), {7'd0, 12'd0, 12'd1, 1'b0});
    run_to(839);
    check("def_hsync_839", 32'(d_hs), 32'd0);
    step();
    check("def_hsync_840", 32'(d_hs), 32'd1);
    run_to(967);
    check("def_hsync_967", 32'(d_hs), 32'd1);
    step();
    check("def_hsync_968", 32'({d_h, 3'b000, d_hs}), {12'd968, 4'b0000});
    run_to(1055);
    check("def_1055", 32'({d_h, d_v, d_hb}), {7'd0, 12'd1055, 12'd0, 1'b1});
    step();
    check("def_line_wrap", 32'({d_h, d_v, d_hb, d_fs}), {6'd0, 12'd0, 12'd1, 2'b00});

    // Vertical behaviour in the tiny mode.
    do_reset();
    run_to(89);
    check("s_vblnk_89", 32'(obs_small()), 32'(pk(12'd14, 12'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)));
    step();
    check("s_vblnk_90", 32'(obs_small()), 32'(pk(12'd0, 12'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));
    run_to(104);
    check("s_vsync_104", 32'(s_vs), 32'd0);
    step();
    check("s_vsync_105", 32'(s_vs), 32'd1);
    run_to(134);
    check("s_vsync_134", 32'(s_vs), 32'd1);
    step();
    check("s_vsync_135", 32'({s_v, 3'b000, s_vs}), {12'd9, 4'b0000});
    run_to(179);
    check("s_last_px", 32'(obs_small()), 32'(pk(12'd14, 12'd11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)));
    step();
    check("s_frame_wrap", 32'(obs_small()), 32'(pk(12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));

    cnt = 0;
    hs_rises = 0;
    vs_hi = 0;
    prev_hs = s_hs;
    do begin
      step();
      cnt++;
      if (cnt == 1) check("s_fs_one_cycle", 32'({s_h, 3'b000, s_fs}), {12'd1, 4'b0000});
      if (s_hs && !prev_hs) hs_rises++;
      prev_hs = s_hs;
      if (s_vs) vs_hi++;
    end while (!s_fs && cnt < 1000);
    check("s_frame_period", 32'(cnt), 32'd180);
    check("s_hsync_pulses", 32'(hs_rises), 32'd12);
    check("s_vsync_cycles", 32'(vs_hi), 32'd30);

    // Mid-frame asynchronous reset, then cycle-for-cycle restart.
    do_reset();
    run_to(116);
    check("s_pre_midrst", 32'(obs_small()), 32'(exp_small(116)));
    #3;
    rst = 1'b1;
    #1;
    check("s_midrst_async", 32'(obs_small()), 32'd0);
    check("def_midrst_async", 32'({d_h, d_v, d_hs, d_hb, d_vs, d_vb, d_fs}), 32'd0);
    repeat (3) @(posedge pclk);
    #1;
    check("s_midrst_held", 32'(obs_small()), 32'd0);
    rst = 1'b0;
    cyc = 0;
    check("s_restart_0", 32'(obs_small()), 32'(exp_small(0)));
    for (int i = 1; i <= 200; i++) begin
      step();
      check($sformatf("s_restart_%0d", i), 32'(obs_small()), 32'(exp_small(i)));
    end
    check("def_restart_hcount", 32'({d_h, d_v}), {8'd0, 12'd200, 12'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
